// File: rtl/graphite_pkg.sv
// Shared types, constants and helpers for the signed 16.16 fixed-point divider.
package graphite_pkg;

  localparam int FRAC_BITS = 16;

  typedef logic signed [31:0] fixed_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

  // |0x80000000| comes out as 2^31 because the result is read as unsigned
  function automatic logic [31:0] magnitude(input fixed_t v);
    return v[31] ? 32'(-v) : 32'(v);
  endfunction

endpackage

// File: rtl/fixed_div_step.sv
// One restoring-division step: shift a dividend bit into the remainder, subtract the divisor if it fits.
// Purely combinational; relies on rem < divisor so the borrow bit alone decides the quotient bit.
module fixed_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] trial;
  logic [W:0] diff;

  assign trial    = {rem, din};
  assign diff     = trial - {1'b0, divisor};
  assign q_bit    = ~diff[W];
  assign rem_next = q_bit ? diff[W-1:0] : trial[W-1:0];

endmodule

// File: rtl/fixed_div_seq.sv
// Sequential signed 16.16 divider, one restoring step per cycle; FIXED_DIV_ROUND_EN adds a rounding step.
// Latency 49 cycles (50 rounded, 1 for b == 0); one op in flight, ready_o only in IDLE, result held until ready_i.
module fixed_div_seq
  import graphite_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] z_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        div_by_zero_o,
  output logic        overflow_o
);

`ifdef FIXED_DIV_ROUND_EN
  localparam int STEPS = 32 + FRAC_BITS + 1;
`else
  localparam int STEPS = 32 + FRAC_BITS;
`endif
  localparam int QW = 32 + FRAC_BITS + 1;

  state_t           state, state_nx;
  logic             accept, finish;
  logic [5:0]       cnt;
  logic [STEPS-1:0] work;
  logic [STEPS-1:0] quot;
  logic [31:0]      rem, rem_nx, dmag;
  logic             neg, q_bit;
  logic [QW-1:0]    qmag;
  fixed_t           z_q, z_sat;
  logic             dbz_q, ovf_q, ovf_sat;

  fixed_div_step #(.W(32)) u_step (
    .rem      (rem),
    .din      (work[STEPS-1]),
    .divisor  (dmag),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: if (valid_i) begin
        accept   = 1'b1;
        state_nx = (b_i == '0) ? DONE : CALC;
      end
      CALC: if (cnt == '0) begin
        finish   = 1'b1;
        state_nx = DONE;
      end
      DONE:    if (ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // work doubles as dividend and quotient: dividend bits leave at the top, quotient bits enter at the bottom
  assign quot = {work[STEPS-2:0], q_bit};

`ifdef FIXED_DIV_ROUND_EN
  // quot carries one extra fraction bit; (quot + 1) >> 1 rounds half away from zero on the magnitude
  assign qmag = {1'b0, quot[STEPS-1:1]} + QW'(quot[0]);
`else
  assign qmag = {1'b0, quot};
`endif

  always_comb begin
    z_sat   = '0;
    ovf_sat = 1'b0;
    if (neg) begin
      if (qmag > QW'(32'h8000_0000)) begin
        z_sat   = FIXED_MIN;
        ovf_sat = 1'b1;
      end else begin
        z_sat = -fixed_t'(qmag[31:0]);
      end
    end else if (qmag > QW'(32'h7FFF_FFFF)) begin
      z_sat   = FIXED_MAX;
      ovf_sat = 1'b1;
    end else begin
      z_sat = fixed_t'(qmag[31:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt   <= '0;
      work  <= '0;
      rem   <= '0;
      dmag  <= '0;
      neg   <= 1'b0;
      z_q   <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      cnt  <= 6'(STEPS - 1);
      work <= {magnitude(a_i), {(STEPS-32){1'b0}}};
      rem  <= '0;
      dmag <= magnitude(b_i);
      neg  <= a_i[31] ^ b_i[31];
      if (b_i == '0) begin
        z_q   <= a_i[31] ? FIXED_MIN : FIXED_MAX;
        dbz_q <= 1'b1;
        ovf_q <= 1'b0;
      end
    end else if (state == CALC) begin
      work <= quot;
      rem  <= rem_nx;
      if (finish) begin
        z_q   <= z_sat;
        dbz_q <= 1'b0;
        ovf_q <= ovf_sat;
      end else begin
        cnt <= cnt - 6'd1;
      end
    end
  end

  assign ready_o       = (state == IDLE);
  assign valid_o       = (state == DONE);
  assign z_o           = z_q;
  assign div_by_zero_o = dbz_q;
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Scoreboarded bench for fixed_div_seq: directed and random ops against a wide-integer reference model.
module tb_fixed_div_seq;

`ifdef FIXED_DIV_ROUND_EN
  localparam int LAT = 50;
  localparam logic [31:0] Z_TWO_THIRDS = 32'h0000_AAAB;
`else
  localparam int LAT = 49;
  localparam logic [31:0] Z_TWO_THIRDS = 32'h0000_AAAA;
`endif

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] z_o;
  logic        valid_o;
  logic        ready_i;
  logic        div_by_zero_o;
  logic        overflow_o;

  fixed_div_seq dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .z_o           (z_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .div_by_zero_o (div_by_zero_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] z;
    logic        dbz;
    logic        ovf;
    int          lat;
    int          acc;
    int          hold;
  } exp_t;

  exp_t scb[$];
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
  endtask

  // Reference: exact rational quotient via 64-bit integers, then the saturation rules
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic dbz, output logic ovf);
    longint sa, sbv, ma, mb, q;
    bit neg;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    neg = (sa < 0) != (sbv < 0);
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 32'h0) begin
      dbz = 1'b1;
      z   = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
`ifdef FIXED_DIV_ROUND_EN
      q = (ma * 131072 + mb) / (2 * mb);
`else
      q = (ma * 65536) / mb;
`endif
      if (!neg && q > 64'sd2147483647) begin
        z = 32'h7FFF_FFFF; ovf = 1'b1;
      end else if (neg && q > 64'sd2147483648) begin
        z = 32'h8000_0000; ovf = 1'b1;
      end else begin
        z = 32'(neg ? -q : q);
      end
    end
  endtask

  function automatic logic [31:0] rand_opnd(input bit is_div);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: rand_opnd = r;
      1: rand_opnd = {{12{r[31]}}, r[19:0]};
      2: rand_opnd = is_div ? 32'h0000_0000 : 32'h8000_0000;
      3: rand_opnd = {{16{r[31]}}, r[15:0]};
      4: rand_opnd = {{8{r[31]}}, r[23:16], 16'h0000};
      default: rand_opnd = is_div ? 32'h0000_0001 : 32'h7FFF_FFFF;
    endcase
  endfunction

  // Called #1 after a rising edge; junk valid_i is driven while the DUT is busy
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z,
                       input logic dbz, input logic ovf, input int hold);
    exp_t e;
    int w;
    w = 0;
    while (!ready_o && w < 300) begin
      valid_i = ($urandom_range(0, 2) == 0);
      a_i = $urandom;
      b_i = $urandom;
      @(posedge clk); #1;
      w++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
      return;
    end
    e.z = z; e.dbz = dbz; e.ovf = ovf; e.hold = hold;
    e.lat = (b == 32'h0) ? 1 : LAT;
    e.acc = cyc + 1;
    scb.push_back(e);
    valid_i = 1'b1;
    a_i = a;
    b_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Monitor: pops an expectation on each new result, checks stability and the handshake
  exp_t cur;
  bit   busy = 0, hs = 0, first = 0, stray = 0;
  int   hold_left = 0;

  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n_i) begin
        busy = 0; hs = 0; ready_i = 1'b0;
        continue;
      end
      if (hs) begin
        hs = 0; busy = 0;
        chk("valid_drop_after_hs", 32'(valid_o), 32'd0);
        chk("ready_after_hs", 32'(ready_o), 32'd1);
      end
      first = 0;
      if (valid_o && !busy) begin
        busy = 1; first = 1;
        if (scb.size() == 0) begin
          chk("result_without_op", 32'(valid_o), 32'd0);
          stray = 1; hold_left = 0;
        end else begin
          cur = scb.pop_front();
          stray = 0; hold_left = cur.hold;
          chk("z", z_o, cur.z);
          chk("div_by_zero", 32'(div_by_zero_o), 32'(cur.dbz));
          chk("overflow", 32'(overflow_o), 32'(cur.ovf));
          chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
        end
      end
      if (busy && valid_o) begin
        if (!stray) begin
          if (!first) begin
            chk("z_hold", z_o, cur.z);
            chk("flags_hold", {30'b0, div_by_zero_o, overflow_o}, {30'b0, cur.dbz, cur.ovf});
          end
          chk("ready_in_done", 32'(ready_o), 32'd0);
        end
        if (hold_left > 0) begin
          hold_left--;
          ready_i = 1'b0;
        end else begin
          ready_i = 1'b1;
          hs = 1;
        end
      end else if (busy) begin
        chk("valid_held", 32'(valid_o), 32'd1);
        busy = 0;
      end else begin
        ready_i = 1'($urandom_range(0, 1));
      end
    end
  end

  logic [31:0] dir_a [10] = '{32'h0003_0000, 32'h0002_0000, 32'hFFFA_0000, 32'h0001_0000, 32'h7FFF_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_0000};
  logic [31:0] dir_b [10] = '{32'h0002_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_0000, 32'h0000_0001,
                              32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0003_0000};
  logic [31:0] dir_z [10] = '{32'h0001_8000, Z_TWO_THIRDS, 32'hFFFD_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                              32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_AAAB};
  logic [1:0]  dir_f [10] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};

  initial begin
    logic [31:0] a, b, z;
    logic dbz, ovf;
    int w;

    #2 reset_n_i = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_z", z_o, 32'd0);
    chk("rst_flags", {30'b0, div_by_zero_o, overflow_o}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      do_op(dir_a[i], dir_b[i], dir_z[i], dir_f[i][1], dir_f[i][0], (i == 0) ? 10 : 0);

    // Reset in the middle of a computation: that op must never produce a result
    do_op(32'h0005_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk) reset_n_i = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_z", z_o, 32'd0);
    chk("midrst_flags", {30'b0, div_by_zero_o, overflow_o}, 32'd0);
    scb.delete();
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 60; i++) begin
      a = rand_opnd(1'b0);
      b = rand_opnd(1'b1);
      model(a, b, z, dbz, ovf);
      do_op(a, b, z, dbz, ovf, int'($urandom_range(0, 3)));
    end

    valid_i = 1'b0;
    w = 0;
    while ((scb.size() != 0 || !ready_o) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(scb.size()), 32'd0);
    chk("drain_idle", 32'(ready_o), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fixed_div_seq.md
FIXED_DIV_SEQ -- requirements
Module: fixed_div_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n_i  input  1  asynchronous active-low reset.
REQ-004 Port: a_i  input  32  dividend, signed 16.16 fixed point.
REQ-005 Port: b_i  input  32  divisor, signed 16.16 fixed point.
REQ-006 Port: valid_i  input  1  operands valid.
REQ-007 Port: ready_o  output  1  block can accept operands.
REQ-008 Port: z_o  output  32  quotient a/b, signed 16.16.
REQ-009 Port: valid_o  output  1  z_o and flags valid.
REQ-010 Port: ready_i  input  1  downstream accepts result.
REQ-011 Port: div_by_zero_o  output  1  b_i was zero; valid with valid_o.
REQ-012 Port: overflow_o  output  1  quotient saturated; valid with valid_o.

Function
REQ-013 SHALL compute z = (a << 16) / b on magnitudes (sign-magnitude), sign = sign(a) XOR sign(b); |0x80000000| = 2^31 handled without wrap.
REQ-014 SHALL be an FSM with states IDLE, CALC, DONE; ready_o = 1 only in IDLE.
REQ-015 IDLE: on valid_i && ready_o, SHALL latch operands; b_i == 0 -> DONE next cycle, else -> CALC with iteration counter loaded to 47.
REQ-016 CALC: SHALL perform one restoring-division step per cycle on a 48-bit dividend |a|<<16, MSB first; 48 steps, then -> DONE.
REQ-017 Latency (acceptance edge to first valid_o cycle) SHALL be 49 cycles for nonzero b and 1 cycle for b == 0.
REQ-018 Default rounding SHALL truncate toward zero.
REQ-019 Unsigned quotient > 0x7FFFFFFF (positive) or > 0x80000000 (negative) SHALL saturate to 0x7FFFFFFF / 0x80000000 with overflow_o = 1.
REQ-020 b == 0 SHALL yield 0x7FFFFFFF if a >= 0 else 0x80000000, div_by_zero_o = 1, overflow_o = 0.
REQ-021 Zero magnitude quotient SHALL yield 0x00000000 (no negative zero issue).
REQ-022 DONE: valid_o = 1; z_o and flags SHALL stay stable until valid_i... until ready_i = 1, then -> IDLE next cycle.
REQ-023 valid_i during CALC/DONE SHALL be ignored; operands are not re-latched.
REQ-024 Back-to-back: next operand acceptance SHALL occur no earlier than the cycle after the result handshake.

Reset
REQ-025 Reset assertion SHALL immediately force IDLE, ready_o = 1, valid_o = 0, z_o = 0, div_by_zero_o = 0, overflow_o = 0, counter = 0.
REQ-026 Reset mid-CALC or mid-DONE SHALL discard the operation; no result is ever emitted for it.

Configuration
REQ-027 Macro FIXED_DIV_ROUND_EN defined: CALC SHALL run 49 steps (one extra fraction bit) and round half away from zero on magnitude before saturation; latency 50 cycles.
REQ-028 Macro undefined: truncation per REQ-018, latency per REQ-017; no rounding logic present.

Structure
REQ-029 graphite_pkg SHALL hold FRAC_BITS = 16, typedef fixed_t (signed 32-bit), and the FSM state enum.
REQ-030 One sub-module SHALL be used: fixed_div_step, combinational single restoring-division step (remainder, dividend bit in -> remainder, quotient bit out).

Verification
REQ-031 a=0x00030000, b=0x00020000 -> z_o=0x00018000, flags 0, valid_o 49 cycles after acceptance.
REQ-032 a=0x00020000, b=0x00030000 -> z_o=0x0000AAAA; with FIXED_DIV_ROUND_EN -> 0x0000AAAB at 50 cycles.
REQ-033 a=0xFFFA0000, b=0x00020000 -> z_o=0xFFFD0000; a=0x00010000, b=0 -> 0x7FFFFFFF, div_by_zero_o=1, valid_o 1 cycle after acceptance.
REQ-034 a=0x7FFF0000, b=0x00000001 -> z_o=0x7FFFFFFF, overflow_o=1.
REQ-035 ready_i held 0 for 10 cycles in DONE -> z_o/flags stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next cycle.
REQ-036 reset_n_i pulsed low at CALC step 20 -> outputs zero at once, ready_o=1; subsequent op 0x00010000/0x00010000 -> 0x00010000.
